// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flow-control unit for a 5-stage RISC-V pipeline: stalls, flushes,
// EX operand-forwarding selects, halt/drain sequencing and saturating event counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int CNT_W        = 32,
    parameter int FWD_EN       = 1,
    parameter int BRANCH_STAGE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             mem_valid,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             redirect,
    input  logic             mem_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] busy_cnt
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_DRAIN,
        MODE_HALTED
    } mode_e;

    mode_e            mode_q;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] busy_cnt_q,  busy_cnt_d;

    // x0 is hard-wired to zero, so a write to it never produces a dependency.
    function automatic logic writes_reg(input logic valid, input logic regwrite,
                                        input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] rs);
        return valid && regwrite && (rd != '0) && (rd == rs);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    logic ex_dep, mem_dep, wb_dep;
    logic hazard;
    logic stall_ev, flush_ev, busy_ev;

    always_comb begin
        ex_dep  = (id_rs1_used && writes_reg(ex_valid, ex_regwrite, ex_rd, id_rs1)) ||
                  (id_rs2_used && writes_reg(ex_valid, ex_regwrite, ex_rd, id_rs2));
        mem_dep = (id_rs1_used && writes_reg(mem_valid, mem_regwrite, mem_rd, id_rs1)) ||
                  (id_rs2_used && writes_reg(mem_valid, mem_regwrite, mem_rd, id_rs2));
        wb_dep  = (id_rs1_used && writes_reg(wb_valid, wb_regwrite, wb_rd, id_rs1)) ||
                  (id_rs2_used && writes_reg(wb_valid, wb_regwrite, wb_rd, id_rs2));
        // Without forwarding, any in-flight producer of a used source must retire first.
        if (FWD_EN != 0) hazard = ex_memread && ex_dep;
        else             hazard = ex_dep || mem_dep || wb_dep;
    end

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN != 0) begin
            if (writes_reg(mem_valid, mem_regwrite, mem_rd, ex_rs1))    fwd_a = FWD_MEM;
            else if (writes_reg(wb_valid, wb_regwrite, wb_rd, ex_rs1))  fwd_a = FWD_WB;
            if (writes_reg(mem_valid, mem_regwrite, mem_rd, ex_rs2))    fwd_b = FWD_MEM;
            else if (writes_reg(wb_valid, wb_regwrite, wb_rd, ex_rs2))  fwd_b = FWD_WB;
        end
    end

    // NOTE: every output gets a default before the priority chain so no path can infer a latch.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (mem_busy) begin
            // Full freeze: redirect and hazard are re-evaluated once memory releases.
        end else if (redirect) begin
            pc_en       = (mode_q == MODE_RUN);
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = (BRANCH_STAGE == 3);
        end else if (hazard) begin
            idex_flush  = 1'b1;
        end else if (mode_q != MODE_RUN) begin
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
        end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
        end
    end

    always_comb begin
        busy_ev  = (mode_q != MODE_HALTED) && mem_busy;
        flush_ev = (mode_q != MODE_HALTED) && !mem_busy && redirect;
        stall_ev = (mode_q != MODE_HALTED) && !mem_busy && !redirect && hazard;
        stall_cnt_d = stall_ev ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_ev ? sat_inc(flush_cnt_q) : flush_cnt_q;
        busy_cnt_d  = busy_ev  ? sat_inc(busy_cnt_q)  : busy_cnt_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_RUN;
            halted_q <= 1'b0;
        end else begin
            case (mode_q)
                MODE_RUN: begin
                    if (halt_req && !mem_busy) mode_q <= MODE_DRAIN;
                end
                MODE_DRAIN: begin
                    if (!ex_valid && !mem_valid && !wb_valid && !mem_busy) begin
                        mode_q   <= MODE_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                MODE_HALTED: begin
                    if (resume) begin
                        mode_q   <= MODE_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    mode_q   <= MODE_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and flow-control unit for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Generates PC/IF-ID enables, per-stage flushes and EX operand-forwarding selects.
- Handles load-use and RAW stalls, taken-branch/jump redirects, multi-cycle data-memory freezes, and a halt/drain mode.
- Keeps saturating event counters for performance analysis.

Parameters:
- REG_W, 5, register-index width
- CNT_W, 32, width of each event counter
- FWD_EN, 1: 1 = forwarding plus load-use stall only; 0 = no forwarding, stall on any RAW hazard
- BRANCH_STAGE, 3: stage whose redirect is consumed; 2 = EX (flush IF/ID, ID/EX); 3 = MEM (also flush EX/MEM)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  REG_W each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  source operand actually read
- ex_rs1, ex_rs2  in  REG_W each  source registers held in ID/EX
- ex_valid, ex_rd, ex_regwrite, ex_memread  in  1/REG_W/1/1  ID/EX stage info
- mem_valid, mem_rd, mem_regwrite  in  1/REG_W/1  EX/MEM stage info
- wb_valid, wb_rd, wb_regwrite  in  1/REG_W/1  MEM/WB stage info
- redirect  in  1  taken branch/jump from stage BRANCH_STAGE
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- halt_req  in  1  request drain and halt
- resume  in  1  leave HALTED
- pc_en, ifid_en  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert bubble (valid=0) next edge
- fwd_a, fwd_b  out  2 each  00 = regfile, 01 = MEM/WB, 10 = EX/MEM
- halted  out  1  registered, high in HALTED
- stall_cnt, flush_cnt, busy_cnt  out  CNT_W each  event counters

Behaviour:
- Reset (async): FSM = RUN, halted = 0, all counters = 0. Combinational outputs follow the rules below from reset state.
- Match definition: X matches rs when X_valid & X_regwrite & X_rd != 0 & X_rd == rs. Register x0 never causes a hazard or a forward.
- Forwarding (FWD_EN = 1), combinational:
  - fwd_a = 10 if mem matches ex_rs1; else 01 if wb matches ex_rs1; else 00. EX/MEM has priority. fwd_b is the same using ex_rs2.
  - With FWD_EN = 0, fwd_a = fwd_b = 00.
- hazard:
  - FWD_EN = 1: ex_memread & (ex matches an id source that is used).
  - FWD_EN = 0: ex, mem or wb matches a used id source.
- Priority per cycle, highest first: mem_busy > redirect > hazard > FSM mode > normal.
  - mem_busy: pc_en = ifid_en = 0, all flushes = 0 (full freeze). Redirect and hazard are re-evaluated after release. busy_cnt increments.
  - redirect: pc_en = 1, ifid_flush = idex_flush = 1, exmem_flush = (BRANCH_STAGE == 3). flush_cnt increments once per non-busy cycle with redirect. The hazard is ignored that cycle because the instruction is squashed.
  - hazard: pc_en = ifid_en = 0, idex_flush = 1 (bubble). stall_cnt increments per stalled cycle.
  - normal: pc_en = ifid_en = 1, no flushes.
- FSM:
  - RUN: halt_req (not busy) -> DRAIN. A redirect in the same cycle is applied first.
  - DRAIN: pc_en = 0 and ifid_flush = 1 each non-busy cycle; downstream stages advance. A redirect still applies its flushes, but pc_en stays 0. Go to HALTED when ex_valid = mem_valid = wb_valid = 0 and not mem_busy.
  - HALTED: halted = 1, pc_en = 0, ifid_flush = 1, counters frozen. resume -> RUN next edge, with halted = 0 after that edge. halt_req is ignored in HALTED.
  - resume outside HALTED is ignored.
- Counters: +1 per qualifying cycle and saturate at all-ones; no wrap.
- Reset mid-drain or mid-stall returns to RUN with counters cleared immediately (asynchronous).

Test Plan:
- FWD_EN = 1, "lw x5" in EX, ID "add x6,x5,x1" with rs1_used = 1 -> one cycle pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cnt 0 -> 1; next cycle ex_memread = 0 -> normal; fwd_a = 01 when lw is in WB.
- ex_rs1 = 7, mem_rd = 7, wb_rd = 7, both regwrite and valid -> fwd_a = 10. Same with mem_rd = 0 or x0 sources -> fwd_a = 01 / 00 respectively.
- BRANCH_STAGE = 3, redirect together with a load-use hazard -> ifid/idex/exmem_flush = 1, pc_en = 1, stall_cnt unchanged, flush_cnt +1. BRANCH_STAGE = 2 -> exmem_flush = 0.
- mem_busy high 3 cycles with redirect held -> all enables 0, no flushes, busy_cnt = 3; release -> redirect flush applied in one cycle.
- halt_req with 3 valid downstream instructions -> DRAIN; halted = 1 after the last valid clears; counters frozen; resume -> RUN with pc_en = 1.
- Force stall_cnt to all-ones (CNT_W = 4, 20 stall cycles) -> holds 15. Async rst mid-DRAIN -> halted = 0, counters = 0 without a clock edge.
